// File: rtl/fp64_to_fp32_pipe.sv
// fp64_to_fp32_pipe: pipelined FP64 -> FP32 narrowing converter.
// Handshake: a stage moves only when adv = !out_valid | out_ready; in_ready = adv,
// a transfer happens on valid & ready, and bubbles travel as valid = 0.
// Stage 1 unpacks/classifies, stage 2 aligns/rounds, optional stage 3 retimes.
// Define FP64_TO_FP32_FTZ_EN to flush tiny results to signed zero.
module fp64_to_fp32_pipe #(
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag
);

   localparam int U_W = 72 + TAG_W;
   localparam int R_W = 36 + TAG_W;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- stage 1: unpack and classify ----------------
   logic [10:0]       u_exp;
   logic [51:0]       u_mant;
   logic              u_nan, u_inf, u_zero, u_hid;
   logic signed [11:0] u_e;
   logic [U_W-1:0]    u_bus;

   // Split the operand into fields and class bits; subnormals get e = -1022
   always_comb begin
      u_exp  = in_data[62:52];
      u_mant = in_data[51:0];
      u_hid  = |u_exp;
      u_nan  = (&u_exp) && (|u_mant);
      u_inf  = (&u_exp) && !(|u_mant);
      u_zero = !u_hid && !(|u_mant);
      u_e    = u_hid ? ($signed({1'b0, u_exp}) - 12'sd1023) : -12'sd1022;
      u_bus  = {in_data[63], u_nan, u_inf, u_zero, u_hid, u_e, u_mant, in_rm, in_tag};
   end

   logic           a_valid;
   logic [U_W-1:0] a_bus;

   generate
      if (PIPE_STAGES >= 2) begin : g_s1_reg
         // Stage-1 register holding the unpacked operand
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_valid <= 1'b0;
               a_bus   <= '0;
            end else if (adv) begin
               a_valid <= in_valid;
               a_bus   <= u_bus;
            end
         end
      end else begin : g_s1_bypass
         assign a_valid = in_valid;
         assign a_bus   = u_bus;
      end
   endgenerate

   logic              a_sign, a_nan, a_inf, a_zero, a_hid;
   logic signed [11:0] a_e;
   logic [51:0]       a_mant;
   logic [2:0]        a_rm;
   logic [TAG_W-1:0]  a_tag;
   assign {a_sign, a_nan, a_inf, a_zero, a_hid, a_e, a_mant, a_rm, a_tag} = a_bus;

   // ---------------- stage 2: align and round ----------------
   logic [52:0] sig53;
   logic [11:0] shamt;
   logic [77:0] ext;
   logic        tiny, big, g, s, rnd, ovf_inf;
   logic [23:0] keep;
   logic [24:0] sum;
   logic [11:0] expb;
   logic [31:0] r_data;
   logic [3:0]  r_flags;

   // Pick the kept significand, guard and sticky, round, then format by class
   always_comb begin
      sig53  = {a_hid, a_mant};
      tiny   = a_e < -12'sd126;
      big    = a_e > 12'sd127;
      shamt  = $unsigned(-12'sd126 - a_e);
      ext    = {sig53, 25'd0} >> shamt;
      keep   = sig53[52:29];
      g      = sig53[28];
      s      = |sig53[27:0];
      if (tiny) begin
         if (shamt >= 12'd26) begin
            keep = 24'd0;
            g    = 1'b0;
            s    = 1'b1;
         end else begin
            keep = ext[77:54];
            g    = ext[53];
            s    = |ext[52:0];
         end
      end
      case (a_rm)
         3'd1:    rnd = 1'b0;
         3'd2:    rnd = a_sign && (g || s);
         3'd3:    rnd = !a_sign && (g || s);
         3'd4:    rnd = g;
         default: rnd = g && (s || keep[0]);
      endcase
      sum  = {1'b0, keep} + {24'd0, rnd};
      expb = $unsigned(a_e) + 12'd127 + {11'd0, sum[24]};
      case (a_rm)
         3'd1:    ovf_inf = 1'b0;
         3'd2:    ovf_inf = a_sign;
         3'd3:    ovf_inf = !a_sign;
         default: ovf_inf = 1'b1;
      endcase
      r_data  = 32'd0;
      r_flags = 4'd0;
      if (a_nan) begin
         r_data  = {a_sign, 8'hFF, 1'b1, a_mant[50:29]};
         r_flags = {!a_mant[51], 3'b000};
      end else if (a_inf) begin
         r_data  = {a_sign, 8'hFF, 23'd0};
      end else if (a_zero) begin
         r_data  = {a_sign, 31'd0};
      end else if (big || (!tiny && expb == 12'd255)) begin
         r_data  = ovf_inf ? {a_sign, 8'hFF, 23'd0} : {a_sign, 8'hFE, 23'h7FFFFF};
         r_flags = 4'b0101;
      end else if (tiny) begin
`ifdef FP64_TO_FP32_FTZ_EN
         r_data  = {a_sign, 31'd0};
         r_flags = 4'b0011;
`else
         r_data  = {a_sign, 7'd0, sum[23:0]};
         r_flags = {2'b00, g || s, g || s};
`endif
      end else begin
         r_data  = {a_sign, expb[7:0], sum[22:0]};
         r_flags = {3'b000, g || s};
      end
   end

   logic [R_W-1:0] r_bus;
   assign r_bus = {r_data, r_flags, a_tag};

   logic           b_valid;
   logic [R_W-1:0] b_bus;

   generate
      if (PIPE_STAGES >= 3) begin : g_s2_reg
         // Stage-2 register holding the rounded result ahead of retiming
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               b_valid <= 1'b0;
               b_bus   <= '0;
            end else if (adv) begin
               b_valid <= a_valid;
               b_bus   <= r_bus;
            end
         end
      end else begin : g_s2_bypass
         assign b_valid = a_valid;
         assign b_bus   = r_bus;
      end
   endgenerate

   // Output register; holds its contents while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_flags <= 4'd0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid                      <= b_valid;
         {out_data, out_flags, out_tag} <= b_bus;
      end
   end

endmodule

// File: tb/tb_fp64_to_fp32_pipe.sv
// Bench for fp64_to_fp32_pipe: directed vectors, backpressure, reset and random traffic
// checked against an arithmetic quantisation model and an expected-result queue.
module tb_fp64_to_fp32_pipe;

   localparam int PIPE_STAGES = 2;
   localparam int TAG_W       = 4;
   localparam int R_W         = 36 + TAG_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [63:0]      in_data = 64'd0;
   logic [2:0]       in_rm = 3'd0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [3:0]       out_flags;
   logic [TAG_W-1:0] out_tag;

   int n_cmp = 0;
   int n_bad = 0;
   logic [R_W-1:0] exp_q[$];

   fp64_to_fp32_pipe #(.PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rm(in_rm), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
      .out_tag(out_tag)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [35:0] ovf_res(input logic sign, input logic [2:0] rm);
      logic to_inf;
      case (rm)
         3'd1:    to_inf = 1'b0;
         3'd2:    to_inf = sign;
         3'd3:    to_inf = !sign;
         default: to_inf = 1'b1;
      endcase
      return {(to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF}), 4'b0101};
   endfunction

   // Value = m * 2^e2; quantise to the FP32 grid (step 2^qe) with the chosen rounding.
   function automatic logic [35:0] model(input logic [63:0] d, input logic [2:0] rm);
      logic sign, inexact, tiny, up;
      longint unsigned m, q, rem, half;
      int ex, e2, p, t, qe, sh, cmp, bexp;
      logic [31:0] res;
      sign = d[63];
      ex   = int'(d[62:52]);
      if (ex == 2047) begin
         if (d[51:0] != 52'd0) return {sign, 8'hFF, 1'b1, d[50:29], ~d[51], 3'b000};
         return {sign, 8'hFF, 23'd0, 4'b0000};
      end
      if (ex == 0 && d[51:0] == 52'd0) return {sign, 31'd0, 4'b0000};
      m = {12'd0, d[51:0]};
      if (ex != 0) m = m | (64'd1 << 52);
      e2 = (ex == 0) ? -1074 : ex - 1075;
      p = 0;
      for (int i = 0; i < 53; i++) if (m[i]) p = i;
      t = e2 + p;
      if (t > 127) return ovf_res(sign, rm);
      tiny = (t < -126);
`ifdef FP64_TO_FP32_FTZ_EN
      if (tiny) return {sign, 31'd0, 4'b0011};
`endif
      qe = (tiny ? -126 : t) - 23;
      sh = qe - e2;
      if (sh > 60) begin
         q = 64'd0; inexact = 1'b1; cmp = -1;
      end else begin
         q       = m >> sh;
         rem     = m - (q << sh);
         half    = 64'd1 << (sh - 1);
         inexact = (rem != 64'd0);
         cmp     = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
      end
      case (rm)
         3'd1:    up = 1'b0;
         3'd2:    up = sign && inexact;
         3'd3:    up = !sign && inexact;
         3'd4:    up = (cmp >= 0);
         default: up = (cmp > 0) || (cmp == 0 && q[0]);
      endcase
      q = q + {63'd0, up};
      if (q == (64'd1 << 24)) begin
         q  = q >> 1;
         qe = qe + 1;
      end
      if (q < (64'd1 << 23)) begin
         res = {sign, 8'd0, q[22:0]};
      end else begin
         bexp = qe + 23 + 127;
         if (bexp >= 255) return ovf_res(sign, rm);
         res = {sign, 8'(bexp), q[22:0]};
      end
      return {res, 2'b00, tiny && inexact, inexact};
   endfunction

   // ---------------- scoreboard / compare process ----------------
   logic           held_v = 1'b0;
   logic [R_W-1:0] held = '0;

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (held_v)
            check("hold", {31'd0, out_valid, out_data, out_flags, out_tag}, {31'd0, 1'b1, held});
         held_v = out_valid && !out_ready;
         held   = {out_data, out_flags, out_tag};
         if (in_valid && in_ready)
            exp_q.push_back({model(in_data, in_rm), in_tag});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: got %h expected none", {out_data, out_flags, out_tag});
            end else begin
               check("result", {24'd0, out_data, out_flags, out_tag}, {24'd0, exp_q.pop_front()});
            end
         end
      end else begin
         held_v = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input logic v, input logic [63:0] d, input logic [2:0] rm,
                              input logic [TAG_W-1:0] tag, input logic ordy, output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_rm     = rm;
      in_tag    = tag;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (rst_n && out_valid && !ordy) check("in_ready_stall", {63'd0, in_ready}, 64'd0);
   endtask

   task automatic send(input logic [63:0] d, input logic [2:0] rm, input logic [TAG_W-1:0] tag);
      logic acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         drive_cycle(1'b1, d, rm, tag, 1'b1, acc);
         n++;
      end
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
      end
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++)
         drive_cycle(1'b0, 64'd0, 3'd0, '0, 1'b1, acc);
      drive_cycle(1'b0, 64'd0, 3'd0, '0, 1'b1, acc);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [63:0] rand_op();
      logic [63:0] r;
      logic [10:0] ex;
      int k;
      r = {$urandom, $urandom};
      k = $urandom_range(0, 15);
      case (k)
         0:       ex = 11'd0;
         1:       ex = 11'h7FF;
         2:       ex = 11'(1023 + 128 + $urandom_range(0, 800));
         3:       ex = 11'(1023 + 127);
         4, 5:    ex = 11'(1023 - 127 - $urandom_range(0, 30));
         6:       ex = 11'(1023 - 126);
         7:       ex = 11'($urandom_range(1, 800));
         default: ex = 11'(1023 - 126 + $urandom_range(0, 253));
      endcase
      if ($urandom_range(0, 3) == 0) r[28:0] = ($urandom_range(0, 1) == 1) ? 29'h10000000 : 29'h0;
      if (k == 3 && $urandom_range(0, 1) == 1) r[51:0] = '1;
      if (k <= 1 && $urandom_range(0, 2) == 0) r[51:0] = '0;
      r[62:52] = ex;
      return r;
   endfunction

   // ---------------- directed vectors ----------------
   localparam int ND = 11;
   logic [63:0] dir_d [ND] = '{64'h3FF0000000000000, 64'h3FF0000010000000, 64'h3FF0000010000000,
                               64'h3FF0000010000000, 64'h3FF0000010000000, 64'h47F0000000000000,
                               64'h47F0000000000000, 64'hC7F0000000000000, 64'h7FF0000000000001,
                               64'hFFF8000000000000, 64'h36A0000000000000};
   logic [2:0]  dir_rm [ND] = '{3'd0, 3'd0, 3'd3, 3'd4, 3'd1, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0};
   logic [35:0] dir_e  [ND] = '{{32'h3F800000, 4'b0000}, {32'h3F800000, 4'b0001},
                               {32'h3F800001, 4'b0001}, {32'h3F800001, 4'b0001},
                               {32'h3F800000, 4'b0001}, {32'h7F800000, 4'b0101},
                               {32'h7F7FFFFF, 4'b0101}, {32'hFF7FFFFF, 4'b0101},
                               {32'h7FC00000, 4'b1000}, {32'hFFC00000, 4'b0000},
`ifdef FP64_TO_FP32_FTZ_EN
                               {32'h00000000, 4'b0011}};
`else
                               {32'h00000001, 4'b0000}};
`endif

   // ---------------- main sequence ----------------
   initial begin
      logic acc;
      logic [63:0] ops [8];
      logic [63:0] cur;
      logic [2:0] cur_rm;
      logic [TAG_W-1:0] cur_tag;
      logic pend, v, ordy;
      int lat, idx, cyc;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_out_bits", {24'd0, out_data, out_flags, out_tag}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // model pinned by hand-computed vectors
      for (int i = 0; i < ND; i++)
         check($sformatf("model_pin%0d", i), {28'd0, model(dir_d[i], dir_rm[i])}, {28'd0, dir_e[i]});

      // latency of the first operand
      drive_cycle(1'b1, 64'h3FF0000000000000, 3'd0, 4'hA, 1'b1, acc);
      check("lat_accept", {63'd0, acc}, 64'd1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         drive_cycle(1'b0, 64'd0, 3'd0, '0, 1'b1, acc);
         if (out_valid && lat == 0) lat = k;
      end
      check("latency", 64'(lat), 64'(PIPE_STAGES));

      // directed vectors through the DUT
      for (int i = 0; i < ND; i++) send(dir_d[i], dir_rm[i], TAG_W'(i));
      drain();

      // 8 operands back to back with a 3-cycle consumer stall mid-stream
      for (int i = 0; i < 8; i++) ops[i] = rand_op() ^ 64'(i);
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 40) begin
         ordy = !(cyc >= 4 && cyc < 7);
         drive_cycle(1'b1, ops[idx], 3'(idx % 5), TAG_W'(idx), ordy, acc);
         if (acc) idx++;
         cyc++;
      end
      check("stream_all_accepted", 64'(idx), 64'd8);
      drain();

      // reset in the middle of traffic
      idx = 0;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, rand_op(), 3'($urandom_range(0, 7)), TAG_W'($urandom), 1'b1, acc);
      end
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      check("mid_reset_out_valid", {63'd0, out_valid}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 64'd0, 3'd0, '0, 1'b1, acc);
         check("post_reset_idle", {63'd0, out_valid}, 64'd0);
      end

      // random traffic with random backpressure
      pend = 1'b0;
      cur = 64'd0;
      cur_rm = 3'd0;
      cur_tag = '0;
      for (int c = 0; c < 800; c++) begin
         if (!pend) begin
            cur     = rand_op();
            cur_rm  = 3'($urandom_range(0, 7));
            cur_tag = TAG_W'($urandom);
         end
         v    = pend || ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 7);
         drive_cycle(v, cur, cur_rm, cur_tag, ordy, acc);
         pend = v && !acc;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
